cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Consumes the committed-instruction exception record (exception_t) produced at the commit boundary.
- Owns the CP0 architectural state: BadVAddr, Count, Compare, Status, Cause and EPC.
- Issues the pipeline redirect to the exception vector on an exception, or to EPC on eret.
- Generates the interrupt-pending signal that the commit stage turns into a CODE_INT record.

Parameters:
- VEC_BEV1, 32'hbfc0_0380, exception vector when Status.BEV=1 (EXC_ENTRY).
- VEC_BEV0, 32'h8000_0180, exception vector when Status.BEV=0 (EXC_BASE_BEV0 + OFFSET_GENERAL).
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, all other bits 0).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- exc_in  in  exception_t  committed exception record; acted on only when .valid=1.
- eret  in  1  eret committed this cycle.
- mtc0_en  in  1  CP0 write strobe.
- mtc0_addr  in  5  CP0 register number.
- mtc0_data  in  32  write data.
- mfc0_addr  in  5  read register number.
- mfc0_data  out  32  combinational read of the current register state.
- ext_int  in  6  hardware interrupt lines, level-sensitive.
- int_pending  out  1  = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (resetn=0, asynchronous, effective at any time including mid-redirect):
  - Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare, TI all 0.
  - redirect_valid=0, redirect_pc=0.
  - Half-rate tick flop = 0.
- Exception (exc_in.valid=1), registered, 1-cycle latency:
  - If Status.EXL=0: EPC = in_delay_slot ? location-4 : location; Cause.BD = in_delay_slot.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Status.EXL=1, Cause.ExcCode=code.
  - Codes ADEL/ADES/TLBL/TLBS/MOD: BadVAddr=exc_in.badvaddr.
  - CODE_CPU: Cause.CE[29:28]=ce[1:0]; all other codes leave CE unchanged.
  - Fields pc and the upper bits of ce are ignored.
  - Next cycle: redirect_valid=1, redirect_pc = (BEV sampled at the exception cycle) ? VEC_BEV1 : VEC_BEV0.
- eret, when exc_in.valid=0:
  - Status.EXL=0.
  - Next cycle: redirect_valid=1, redirect_pc = EPC value at the eret cycle.
- Priority: exception > eret > mtc0.
  - In a cycle with exc_in.valid=1, eret and mtc0 are dropped entirely.
  - eret together with mtc0: both apply; eret's EXL clear wins over a Status write.
- mtc0 write masks:
  - Status: bits 22, 15:8, 1, 0.
  - Cause: bits 9:8 only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr and unlisted numbers: ignored.
  - A write is visible on mfc0_data the following cycle.
  - Unimplemented numbers read as 0.
- Timer:
  - Tick toggles every cycle; Count increments (wrapping 32'hffff_ffff -> 0) on cycles where tick=1.
  - An mtc0 to Count loads the written value in place of the increment; tick is unaffected.
  - TI (Cause bit 30) is set the cycle after Count==Compare.
  - A Compare write clears TI and beats a same-cycle set.
  - TI stays set until Compare is written.
- Cause.IP[7:2] is registered every cycle as {ext_int[5]|TI, ext_int[4:0]}.
- redirect_valid is high for exactly one cycle per accepted event. Back-to-back events give back-to-back pulses.

Decomposition:
- New package cp0_pkg, importing common and exception_pkg, holds:
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - Status/Cause bit positions and write masks.
  - STATUS_RST.
  - Packed cp0_regs_t struct.
- Vector constants reuse EXC_ENTRY / EXC_BASE_BEV0 / OFFSET_GENERAL.
- One sub-module, cp0_timer: tick, Count, Compare, TI, with write ports.

Test Plan:
- Reset, then exc_in {valid=1, location=32'h8000_1004, in_delay_slot=1, code=CODE_ADEL, badvaddr=32'h0000_0003}:
  - Next cycle redirect_valid=1, redirect_pc=32'hbfc0_0380.
  - EPC=32'h8000_1000, BD=1, ExcCode=4, BadVAddr=3, EXL=1.
- With EXL=1, a second exception CODE_SYS at location 32'h8000_2000:
  - EPC stays 32'h8000_1000; ExcCode=8; redirect issued.
- eret:
  - Next cycle redirect_pc=EPC; EXL=0.
  - Then mtc0 Status=32'h0000_ff01 with BEV=0; an exception now redirects to 32'h8000_0180.
- Compare=10, Count=0:
  - TI and Cause bit 15 assert about 21 cycles later.
  - With Status=32'h0000_8001, int_pending=1.
  - mtc0 Compare clears TI.
- Same cycle exc_in.valid, eret and mtc0 EPC=32'h1234:
  - Only the exception takes effect; EPC does not become 32'h1234.
- Assert resetn low the cycle redirect_valid=1:
  - Outputs drop to 0 immediately; Status reads 32'h0040_0000.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 register numbers, field positions, write masks and register bundle.
package cp0_pkg;
  import exception_pkg::*;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int ST_BEV = 22;
  localparam int ST_EXL = 1;
  localparam int ST_IE  = 0;

  localparam logic [31:0] STATUS_WMASK = 32'h0040_ff03;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

  localparam logic [31:0] VEC_BEV1 = EXC_ENTRY;
  localparam logic [31:0] VEC_BEV0 = EXC_BASE_BEV0 + OFFSET_GENERAL;

  // Cause is kept as separate fields; TI lives in the timer.
  typedef struct packed {
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        cause_bd;
    logic [1:0]  cause_ce;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exccode;
  } cp0_regs_t;

  localparam cp0_regs_t CP0_REGS_RST = '{
    status:        STATUS_RST,
    epc:           32'h0,
    badvaddr:      32'h0,
    cause_bd:      1'b0,
    cause_ce:      2'b0,
    cause_ip:      8'h0,
    cause_exccode: 5'h0
  };

  // Address-related exceptions capture the faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == CODE_ADEL) || (code == CODE_ADES) || (code == CODE_TLBL) ||
           (code == CODE_TLBS) || (code == CODE_MOD);
  endfunction

endpackage

// File: rtl/exception_pkg.sv
// Exception record shared between the commit stage and CP0, plus the
// architectural exception codes and vector constants.
package exception_pkg;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_MOD  = 5'd1;
  localparam logic [4:0] CODE_TLBL = 5'd2;
  localparam logic [4:0] CODE_TLBS = 5'd3;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_CPU  = 5'd11;
  localparam logic [4:0] CODE_OV   = 5'd12;

  localparam logic [31:0] EXC_ENTRY      = 32'hbfc0_0380;
  localparam logic [31:0] EXC_BASE_BEV0  = 32'h8000_0000;
  localparam logic [31:0] OFFSET_GENERAL = 32'h0000_0180;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] location;
    logic        in_delay_slot;
    logic [4:0]  code;
    logic [31:0] badvaddr;
    logic [2:0]  ce;
  } exception_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI latches on match.
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        tick_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;

  // Half-rate tick, Count/Compare update and sticky TI (Compare write wins).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q    <= 1'b0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      ti_q      <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (count_we)
        count_q <= wdata;
      else if (tick_q)
        count_q <= count_q + 32'd1;
      if (compare_we)
        compare_q <= wdata;
      if (compare_we)
        ti_q <= 1'b0;
      else if (count_q == compare_q)
        ti_q <= 1'b1;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 architectural state, exception/eret redirect and interrupt pending.
module cp0_exception_unit
  import exception_pkg::*;
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  exception_t  exc_in,
  input  logic        eret,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  input  logic [5:0]  ext_int,
  output logic        int_pending,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  cp0_regs_t   regs_q;
  cp0_regs_t   regs_d;
  logic        redirect_valid_d;
  logic [31:0] redirect_pc_d;
  logic        wr_ok;
  logic        count_we;
  logic        compare_we;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [31:0] cause_word;
  logic        unused_exc;

  assign unused_exc = ^{exc_in.pc, exc_in.ce[2]};

  // An exception in the same cycle swallows any mtc0, including timer writes.
  assign wr_ok      = mtc0_en & ~exc_in.valid;
  assign count_we   = wr_ok & (mtc0_addr == CP0_COUNT);
  assign compare_we = wr_ok & (mtc0_addr == CP0_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (mtc0_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Next architectural state: exception beats eret, eret's EXL clear beats mtc0.
  always_comb begin
    regs_d                = regs_q;
    redirect_valid_d      = 1'b0;
    redirect_pc_d         = redirect_pc;
    regs_d.cause_ip[7:2]  = {ext_int[5] | ti, ext_int[4:0]};
    if (exc_in.valid) begin
      if (!regs_q.status[ST_EXL]) begin
        regs_d.epc      = exc_in.in_delay_slot ? exc_in.location - 32'd4 : exc_in.location;
        regs_d.cause_bd = exc_in.in_delay_slot;
      end
      regs_d.status[ST_EXL] = 1'b1;
      regs_d.cause_exccode  = exc_in.code;
      if (is_addr_exc(exc_in.code))
        regs_d.badvaddr = exc_in.badvaddr;
      if (exc_in.code == CODE_CPU)
        regs_d.cause_ce = exc_in.ce[1:0];
      redirect_valid_d = 1'b1;
      redirect_pc_d    = regs_q.status[ST_BEV] ? VEC_BEV1 : VEC_BEV0;
    end else begin
      if (mtc0_en) begin
        case (mtc0_addr)
          CP0_STATUS: regs_d.status = (regs_q.status & ~STATUS_WMASK) | (mtc0_data & STATUS_WMASK);
          CP0_CAUSE:  regs_d.cause_ip[1:0] = mtc0_data[9:8];
          CP0_EPC:    regs_d.epc = mtc0_data;
          default:    ;
        endcase
      end
      if (eret) begin
        regs_d.status[ST_EXL] = 1'b0;
        redirect_valid_d      = 1'b1;
        redirect_pc_d         = regs_q.epc;
      end
    end
  end

  // State and redirect registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs_q         <= CP0_REGS_RST;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      regs_q         <= regs_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

  assign cause_word = {regs_q.cause_bd, ti, regs_q.cause_ce, 12'h0,
                       regs_q.cause_ip, 1'b0, regs_q.cause_exccode, 2'b00};

  // Combinational register read; unimplemented numbers return zero.
  always_comb begin
    mfc0_data = 32'h0;
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_data = regs_q.badvaddr;
      CP0_COUNT:    mfc0_data = count;
      CP0_COMPARE:  mfc0_data = compare;
      CP0_STATUS:   mfc0_data = regs_q.status;
      CP0_CAUSE:    mfc0_data = cause_word;
      CP0_EPC:      mfc0_data = regs_q.epc;
      default:      mfc0_data = 32'h0;
    endcase
  end

  assign int_pending = regs_q.status[ST_IE] & ~regs_q.status[ST_EXL] &
                       (|(regs_q.cause_ip & regs_q.status[15:8]));

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed scenarios plus random traffic.
module tb_cp0_exception_unit;
  import exception_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  exception_t  exc_in;
  logic        eret;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic [5:0]  ext_int;
  logic        int_pending;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int failures = 0;

  cp0_exception_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .exc_in         (exc_in),
    .eret           (eret),
    .mtc0_en        (mtc0_en),
    .mtc0_addr      (mtc0_addr),
    .mtc0_data      (mtc0_data),
    .mfc0_addr      (mfc0_addr),
    .mfc0_data      (mfc0_data),
    .ext_int        (ext_int),
    .int_pending    (int_pending),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_status, m_epc, m_bva, m_count, m_cmp, m_rpc;
  logic        m_bd, m_ti, m_tick, m_rv;
  logic [1:0]  m_ce;
  logic [7:0]  m_ip;
  logic [4:0]  m_exc;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return {m_bd, m_ti, m_ce, 12'h0, m_ip, 1'b0, m_exc, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_int();
    return m_status[0] & ~m_status[1] & (|(m_ip & m_status[15:8]));
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000;
    m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0; m_rpc = 0;
    m_bd = 0; m_ti = 0; m_tick = 0; m_rv = 0; m_ce = 0; m_ip = 0; m_exc = 0;
  endtask

  task automatic model_step();
    logic [31:0] n_status, n_epc, n_bva, n_count, n_cmp, n_rpc;
    logic        n_bd, n_ti, n_rv;
    logic [1:0]  n_ce;
    logic [7:0]  n_ip;
    logic [4:0]  n_exc;
    logic [4:0]  c;
    n_status = m_status; n_epc = m_epc; n_bva = m_bva; n_cmp = m_cmp; n_rpc = m_rpc;
    n_bd = m_bd; n_ce = m_ce; n_exc = m_exc; n_rv = 1'b0;
    n_count = m_tick ? m_count + 1 : m_count;
    n_ti = m_ti || (m_count == m_cmp);
    n_ip = {ext_int[5] | m_ti, ext_int[4:0], m_ip[1:0]};
    if (exc_in.valid) begin
      c = exc_in.code;
      if (!m_status[1]) begin
        n_epc = exc_in.in_delay_slot ? exc_in.location - 4 : exc_in.location;
        n_bd  = exc_in.in_delay_slot;
      end
      n_status[1] = 1'b1;
      n_exc = c;
      if (c == 5'd4 || c == 5'd5 || c == 5'd2 || c == 5'd3 || c == 5'd1) n_bva = exc_in.badvaddr;
      if (c == 5'd11) n_ce = exc_in.ce[1:0];
      n_rv = 1'b1;
      n_rpc = m_status[22] ? 32'hbfc0_0380 : 32'h8000_0180;
    end else begin
      if (mtc0_en) begin
        case (mtc0_addr)
          5'd9:  n_count = mtc0_data;
          5'd11: begin n_cmp = mtc0_data; n_ti = 1'b0; end
          5'd12: n_status = (m_status & ~32'h0040_ff03) | (mtc0_data & 32'h0040_ff03);
          5'd13: n_ip[1:0] = mtc0_data[9:8];
          5'd14: n_epc = mtc0_data;
          default: ;
        endcase
      end
      if (eret) begin
        n_status[1] = 1'b0;
        n_rv = 1'b1;
        n_rpc = m_epc;
      end
    end
    m_tick = ~m_tick;
    m_status = n_status; m_epc = n_epc; m_bva = n_bva; m_count = n_count; m_cmp = n_cmp;
    m_rpc = n_rpc; m_bd = n_bd; m_ti = n_ti; m_rv = n_rv; m_ce = n_ce; m_ip = n_ip; m_exc = n_exc;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk("cmp_mfc0", mfc0_data, model_read(mfc0_addr));
      chk("cmp_int_pending", {31'h0, int_pending}, {31'h0, model_int()});
      chk("cmp_redirect_valid", {31'h0, redirect_valid}, {31'h0, m_rv});
      if (m_rv) chk("cmp_redirect_pc", redirect_pc, m_rpc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    mfc0_addr = a;
    #1;
    v = mfc0_data;
  endtask

  task automatic idle();
    exc_in = '0; eret = 0; mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0; ext_int = 0;
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] loc, input logic ids,
                         input logic [31:0] bva);
    exc_in = '0;
    exc_in.valid = 1'b1;
    exc_in.code = code;
    exc_in.location = loc;
    exc_in.in_delay_slot = ids;
    exc_in.badvaddr = bva;
    exc_in.pc = loc;
  endtask

  task automatic set_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1'b1; mtc0_addr = a; mtc0_data = d;
  endtask

  logic [4:0] code_tab [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
  logic [4:0] reg_tab  [7]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};

  task automatic rand_inputs();
    idle();
    ext_int = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 9) == 0) begin
      set_exc(code_tab[$urandom_range(0, 10)], $urandom, 1'($urandom_range(0, 1)), $urandom);
      exc_in.ce = 3'($urandom_range(0, 7));
    end
    eret = ($urandom_range(0, 11) == 0);
    if ($urandom_range(0, 5) == 0) begin
      mtc0_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : reg_tab[$urandom_range(0, 5)];
      mtc0_data = $urandom;
      if (mtc0_addr == 5'd9 && $urandom_range(0, 1) == 1) mtc0_data = m_cmp - $urandom_range(0, 8);
      if (mtc0_addr == 5'd11 && $urandom_range(0, 1) == 1) mtc0_data = m_count + $urandom_range(0, 8);
      mtc0_en = 1'b1;
    end
    mfc0_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : reg_tab[$urandom_range(0, 6)];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    int n;
    idle();
    mfc0_addr = 5'd12;
    resetn = 1'b0;
    repeat (3) cyc();
    resetn = 1'b1;
    rd(5'd12, v);
    chk("reset_status", v, 32'h0040_0000);
    chk("reset_redirect", {31'h0, redirect_valid}, 32'h0);
    rd(5'd14, v);
    chk("reset_epc", v, 32'h0);

    // Exception with BEV=1 from a delay slot.
    set_exc(CODE_ADEL, 32'h8000_1004, 1'b1, 32'h0000_0003);
    cyc();
    idle();
    chk("exc1_rv", {31'h0, redirect_valid}, 32'h1);
    chk("exc1_pc", redirect_pc, 32'hbfc0_0380);
    rd(5'd14, v); chk("exc1_epc", v, 32'h8000_1000);
    rd(5'd13, v); chk("exc1_cause", v & 32'h8000_007c, 32'h8000_0010);
    rd(5'd8, v);  chk("exc1_badvaddr", v, 32'h0000_0003);
    rd(5'd12, v); chk("exc1_status", v, 32'h0040_0002);
    chk("model_pin_epc", m_epc, 32'h8000_1000);

    // Nested exception while EXL=1.
    set_exc(CODE_SYS, 32'h8000_2000, 1'b0, 32'hdead_beef);
    cyc();
    idle();
    chk("exc2_rv", {31'h0, redirect_valid}, 32'h1);
    chk("exc2_pc", redirect_pc, 32'hbfc0_0380);
    rd(5'd14, v); chk("exc2_epc", v, 32'h8000_1000);
    rd(5'd13, v); chk("exc2_exccode", v & 32'h0000_007c, 32'h0000_0020);
    rd(5'd8, v);  chk("exc2_badvaddr", v, 32'h0000_0003);

    // eret back to EPC.
    eret = 1'b1;
    cyc();
    idle();
    chk("eret_rv", {31'h0, redirect_valid}, 32'h1);
    chk("eret_pc", redirect_pc, 32'h8000_1000);
    rd(5'd12, v); chk("eret_status", v, 32'h0040_0000);

    // BEV=0 then exception.
    set_mtc0(5'd12, 32'h0000_ff01);
    cyc();
    idle();
    chk("pulse_one_cycle", {31'h0, redirect_valid}, 32'h0);
    rd(5'd12, v); chk("mtc0_status", v, 32'h0000_ff01);
    set_exc(CODE_BP, 32'h8000_4000, 1'b0, 32'h0);
    cyc();
    idle();
    chk("exc3_pc", redirect_pc, 32'h8000_0180);
    rd(5'd14, v); chk("exc3_epc", v, 32'h8000_4000);
    eret = 1'b1;
    cyc();
    idle();
    chk("eret2_pc", redirect_pc, 32'h8000_4000);

    // Timer: Count=0 then Compare=10, wait for TI.
    set_mtc0(5'd9, 32'h0);
    cyc();
    set_mtc0(5'd11, 32'd10);
    cyc();
    idle();
    rd(5'd13, v); chk("ti_cleared", {31'h0, v[30]}, 32'h0);
    n = 0;
    do begin
      cyc();
      n++;
      rd(5'd13, v);
    end while (!v[30] && n < 40);
    chk("ti_latency_in_range", {31'h0, (n >= 17 && n <= 23)}, 32'h1);
    set_mtc0(5'd12, 32'h0000_8001);
    cyc();
    idle();
    cyc();
    rd(5'd13, v); chk("ti_ip7", {31'h0, v[15]}, 32'h1);
    chk("ti_int_pending", {31'h0, int_pending}, 32'h1);
    set_mtc0(5'd11, 32'hffff_0000);
    cyc();
    idle();
    rd(5'd13, v); chk("ti_clear_by_compare", {31'h0, v[30]}, 32'h0);
    cyc();
    cyc();
    chk("int_pending_drop", {31'h0, int_pending}, 32'h0);

    // Exception, eret and mtc0 EPC in the same cycle.
    set_exc(CODE_SYS, 32'h8000_3000, 1'b0, 32'h0);
    eret = 1'b1;
    set_mtc0(5'd14, 32'h0000_1234);
    cyc();
    idle();
    chk("prio_pc", redirect_pc, 32'h8000_0180);
    rd(5'd14, v); chk("prio_epc", v, 32'h8000_3000);
    rd(5'd12, v); chk("prio_status", v, 32'h0000_8003);
    eret = 1'b1;
    set_mtc0(5'd12, 32'h0000_0003);
    cyc();
    idle();
    rd(5'd12, v); chk("eret_mtc0_exl", v, 32'h0000_0001);

    // Random traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
    end
    idle();

    // Asynchronous reset while a redirect pulse is up.
    set_exc(CODE_OV, 32'h8000_5000, 1'b0, 32'h0);
    cyc();
    idle();
    chk("pre_reset_rv", {31'h0, redirect_valid}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("async_rv", {31'h0, redirect_valid}, 32'h0);
    chk("async_pc", redirect_pc, 32'h0);
    rd(5'd12, v); chk("async_status", v, 32'h0040_0000);
    cyc();
    resetn = 1'b1;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
